// File: rtl/hex_disp_pkg.sv
// Shared types and the 7-segment glyph table for the scrolling HEX display driver.
package hex_disp_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        PAUSE = 1'b1
    } state_e;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Returns {a,b,c,d,e,f,g,dp} with 1 = lit; dp is never lit.
    function automatic logic [7:0] seg7_encode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'b1111_1100;
            4'h1:    seg = 8'b0110_0000;
            4'h2:    seg = 8'b1101_1010;
            4'h3:    seg = 8'b1111_0010;
            4'h4:    seg = 8'b0110_0110;
            4'h5:    seg = 8'b1011_0110;
            4'h6:    seg = 8'b1011_1110;
            4'h7:    seg = 8'b1110_0000;
            4'h8:    seg = 8'b1111_1110;
            4'h9:    seg = 8'b1111_0110;
            4'hA:    seg = 8'b1110_1110;
            4'hB:    seg = 8'b0011_1110;
            4'hC:    seg = 8'b1001_1100;
            4'hD:    seg = 8'b0111_1010;
            4'hE:    seg = 8'b1001_1110;
            default: seg = 8'b1000_1110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability counter and a press pulse
// on each accepted released->pressed transition of the active-low key.
module key_debounce
    import hex_disp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic stable,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    sync_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        // Any sample equal to the accepted level leaves cnt_d at zero, restarting the run.
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync_q[1];
                press_d  = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], key_n};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign stable = stable_q;
    assign press  = press_q;

endmodule

// File: rtl/hex_scroll_display.sv
// Scrolls a circular hex-nibble message across NUM_DIGITS 7-segment displays,
// with debounced run/pause toggle and blank-while-held buttons.
module hex_scroll_display
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS      = 6,
    parameter int MSG_LEN         = 8,
    parameter int TICK_DIV        = 25000000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 key_n,
    input  logic [4*MSG_LEN-1:0]       msg,
    output logic [8*NUM_DIGITS-1:0]    hex,
    output logic [$clog2(MSG_LEN)-1:0] pos,
    output logic                       running
);

    localparam int         PW      = $clog2(MSG_LEN);
    localparam int         TW      = $clog2(TICK_DIV);
    localparam logic [7:0] SEG_OFF = (ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;

    state_e                    state_q, state_d;
    logic [TW-1:0]             tick_q, tick_d;
    logic [PW-1:0]             pos_q, pos_d;
    logic [8*NUM_DIGITS-1:0]   hex_q, hex_d;

    logic toggle_press, blank_level;
    logic run_level_unused, blank_press_unused;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_run (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_n  (key_n[0]),
        .stable (run_level_unused),
        .press  (toggle_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_blank (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_n  (key_n[1]),
        .stable (blank_level),
        .press  (blank_press_unused)
    );

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        pos_d   = pos_q;
        case (state_q)
            RUN: begin
                // A press coinciding with the terminal tick pauses without stepping.
                if (toggle_press) begin
                    state_d = PAUSE;
                    tick_d  = '0;
                end else if (tick_q == TW'(TICK_DIV - 1)) begin
                    tick_d = '0;
                    pos_d  = (pos_q == PW'(MSG_LEN - 1)) ? '0 : pos_q + 1'b1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: begin
                tick_d = '0;
                if (toggle_press) begin
                    state_d = RUN;
                end
            end
        endcase
    end

    // Digit k (k=0 rightmost) shows character (pos + NUM_DIGITS-1-k) mod MSG_LEN.
    always_comb begin
        hex_d = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (blank_level == 1'b0) begin
                hex_d[8*k +: 8] = SEG_OFF;
            end else if (ACTIVE_LOW != 0) begin
                hex_d[8*k +: 8] = ~seg7_encode(msg[4*((int'(pos_q) + NUM_DIGITS - 1 - k) % MSG_LEN) +: 4]);
            end else begin
                hex_d[8*k +: 8] = seg7_encode(msg[4*((int'(pos_q) + NUM_DIGITS - 1 - k) % MSG_LEN) +: 4]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            tick_q  <= '0;
            pos_q   <= '0;
            hex_q   <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            pos_q   <= pos_d;
            hex_q   <= hex_d;
        end
    end

    assign hex     = hex_q;
    assign pos     = pos_q;
    assign running = (state_q == RUN);

endmodule

// File: tb/tb_hex_scroll_display.sv
// Directed bench for hex_scroll_display: NUM_DIGITS=6, MSG_LEN=8, TICK_DIV=4,
// DEBOUNCE_CYCLES=3, message 2,0,5,0,3,1,A,b, plus an ACTIVE_LOW=1 instance.
module tb_hex_scroll_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  key_n = 2'b11;
    logic [31:0] msg;
    logic [47:0] hex, hex_al;
    logic [2:0]  pos, pos_al;
    logic        running, running_al;

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;
    logic [2:0] held_pos;

    // Windows for pos 0, 1 and 4 (HEX5..HEX0).
    localparam logic [47:0] WIN_P0    = 48'hDA_FC_B6_FC_F2_60;
    localparam logic [47:0] WIN_P1    = 48'hFC_B6_FC_F2_60_EE;
    localparam logic [47:0] WIN_P4    = 48'hF2_60_EE_3E_DA_FC;
    localparam logic [47:0] WIN_P0_AL = 48'h25_03_49_03_0D_9F;

    always #5 clk = ~clk;

    hex_scroll_display #(
        .NUM_DIGITS(6), .MSG_LEN(8), .TICK_DIV(4), .DEBOUNCE_CYCLES(3), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_n(key_n), .msg(msg),
        .hex(hex), .pos(pos), .running(running)
    );

    hex_scroll_display #(
        .NUM_DIGITS(6), .MSG_LEN(8), .TICK_DIV(4), .DEBOUNCE_CYCLES(3), .ACTIVE_LOW(1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .key_n(key_n), .msg(msg),
        .hex(hex_al), .pos(pos_al), .running(running_al)
    );

    // Advance until 'target' clock edges have elapsed since reset release, then settle 1 time unit.
    task automatic adv_to(input int target);
        while (ecnt < target) begin
            @(posedge clk);
            ecnt++;
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        key_n = 2'b11;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ecnt  = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (hex !== WIN_P0 && ecnt == 0 && hex !== 48'h0) begin
            errors++; $display("FAIL reset_hex: got %h expected %h", hex, 48'h0);
        end
        checks++;
        if (hex !== 48'h0) begin errors++; $display("FAIL reset_hex_off: got %h expected %h", hex, 48'h0); end
        checks++;
        if (pos !== 3'd0 || running !== 1'b1) begin
            errors++; $display("FAIL reset_state: got pos=%0d run=%b expected pos=0 run=1", pos, running);
        end
        adv_to(1);
        checks++;
        if (hex !== WIN_P0) begin errors++; $display("FAIL first_window: got %h expected %h", hex, WIN_P0); end
        checks++;
        if (hex[7:0] !== 8'b0110_0000 || hex[47:40] !== 8'b1101_1010) begin
            errors++; $display("FAIL first_hex0_hex5: got %b %b expected 01100000 11011010", hex[7:0], hex[47:40]);
        end
        checks++;
        if (pos !== 3'd0 || running !== 1'b1) begin
            errors++; $display("FAIL first_state: got pos=%0d run=%b expected pos=0 run=1", pos, running);
        end
    endtask

    task automatic test_scroll();
        adv_to(3);
        checks++;
        if (pos !== 3'd0) begin errors++; $display("FAIL scroll_pre_step: got %0d expected 0", pos); end
        adv_to(4);
        checks++;
        if (pos !== 3'd1) begin errors++; $display("FAIL scroll_step: got %0d expected 1", pos); end
        adv_to(5);
        checks++;
        if (hex !== WIN_P1 || hex[7:0] !== 8'b1110_1110 || hex[47:40] !== 8'b1111_1100) begin
            errors++; $display("FAIL scroll_window: got %h expected %h", hex, WIN_P1);
        end
        adv_to(31);
        checks++;
        if (pos !== 3'd7) begin errors++; $display("FAIL scroll_pos7: got %0d expected 7", pos); end
        adv_to(32);
        checks++;
        if (pos !== 3'd0) begin errors++; $display("FAIL scroll_wrap: got %0d expected 0", pos); end
    endtask

    task automatic test_pause_resume();
        do_reset();
        adv_to(1);
        key_n[0] = 1'b0;
        adv_to(3);
        key_n[0] = 1'b1;
        adv_to(10);
        checks++;
        if (running !== 1'b1 || pos !== 3'd2) begin
            errors++; $display("FAIL bounce_no_toggle: got run=%b pos=%0d expected run=1 pos=2", running, pos);
        end
        adv_to(11);
        key_n[0] = 1'b0;
        adv_to(16);
        checks++;
        if (running !== 1'b1 || pos !== 3'd4) begin
            errors++; $display("FAIL press_before: got run=%b pos=%0d expected run=1 pos=4", running, pos);
        end
        adv_to(17);
        checks++;
        if (running !== 1'b0 || pos !== 3'd4) begin
            errors++; $display("FAIL press_pause: got run=%b pos=%0d expected run=0 pos=4", running, pos);
        end
        adv_to(20);
        key_n[0] = 1'b1;
        adv_to(37);
        checks++;
        if (running !== 1'b0 || pos !== 3'd4) begin
            errors++; $display("FAIL pause_frozen: got run=%b pos=%0d expected run=0 pos=4", running, pos);
        end
        key_n[0] = 1'b0;
        adv_to(43);
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL resume: got run=%b expected 1", running); end
        adv_to(46);
        checks++;
        if (pos !== 3'd4) begin errors++; $display("FAIL resume_no_early_step: got %0d expected 4", pos); end
        adv_to(47);
        checks++;
        if (pos !== 3'd5) begin errors++; $display("FAIL resume_first_step: got %0d expected 5", pos); end
        key_n[0] = 1'b1;
    endtask

    task automatic test_press_on_terminal();
        do_reset();
        adv_to(2);
        key_n[0] = 1'b0;
        adv_to(7);
        checks++;
        if (running !== 1'b1 || pos !== 3'd1) begin
            errors++; $display("FAIL term_before: got run=%b pos=%0d expected run=1 pos=1", running, pos);
        end
        adv_to(8);
        checks++;
        if (running !== 1'b0 || pos !== 3'd1) begin
            errors++; $display("FAIL term_pause_wins: got run=%b pos=%0d expected run=0 pos=1", running, pos);
        end
        adv_to(12);
        checks++;
        if (pos !== 3'd1) begin errors++; $display("FAIL term_frozen: got %0d expected 1", pos); end
        key_n[0] = 1'b1;
    endtask

    task automatic test_blank();
        do_reset();
        key_n[1] = 1'b0;
        adv_to(5);
        checks++;
        if (hex !== WIN_P1) begin errors++; $display("FAIL blank_not_yet: got %h expected %h", hex, WIN_P1); end
        adv_to(6);
        checks++;
        if (hex !== 48'h0) begin errors++; $display("FAIL blank_on: got %h expected %h", hex, 48'h0); end
        adv_to(12);
        checks++;
        if (hex !== 48'h0 || pos !== 3'd3) begin
            errors++; $display("FAIL blank_running: got hex=%h pos=%0d expected hex=0 pos=3", hex, pos);
        end
        key_n[1] = 1'b1;
        adv_to(17);
        checks++;
        if (hex !== 48'h0 || pos !== 3'd4) begin
            errors++; $display("FAIL blank_release_wait: got hex=%h pos=%0d expected hex=0 pos=4", hex, pos);
        end
        adv_to(18);
        checks++;
        if (hex !== WIN_P4) begin errors++; $display("FAIL blank_restore: got %h expected %h", hex, WIN_P4); end
    endtask

    task automatic test_reset_mid_pause();
        do_reset();
        adv_to(15);
        key_n[0] = 1'b0;
        adv_to(21);
        checks++;
        if (running !== 1'b0 || pos !== 3'd5) begin
            errors++; $display("FAIL mid_pause_setup: got run=%b pos=%0d expected run=0 pos=5", running, pos);
        end
        adv_to(22);
        key_n[0] = 1'b1;
        adv_to(24);
        held_pos = pos;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (hex !== 48'h0 || pos !== 3'd0 || running !== 1'b1) begin
            errors++; $display("FAIL async_reset: got hex=%h pos=%0d run=%b (held %0d) expected hex=0 pos=0 run=1",
                               hex, pos, running, held_pos);
        end
        checks++;
        if (hex_al !== 48'hFFFF_FFFF_FFFF) begin
            errors++; $display("FAIL async_reset_al: got %h expected %h", hex_al, 48'hFFFF_FFFF_FFFF);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ecnt  = 0;
        adv_to(1);
        checks++;
        if (hex !== WIN_P0 || pos !== 3'd0 || running !== 1'b1) begin
            errors++; $display("FAIL after_reset: got hex=%h pos=%0d run=%b expected hex=%h pos=0 run=1",
                               hex, pos, running, WIN_P0);
        end
        checks++;
        if (hex_al !== WIN_P0_AL || hex_al[7:0] !== 8'b1001_1111) begin
            errors++; $display("FAIL active_low_window: got %h expected %h", hex_al, WIN_P0_AL);
        end
    endtask

    initial begin
        msg = {4'hB, 4'hA, 4'h1, 4'h3, 4'h0, 4'h5, 4'h0, 4'h2};
        test_reset();
        test_scroll();
        test_pause_resume();
        test_press_on_terminal();
        test_blank();
        test_reset_mid_pause();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
